// File: rtl/lenet_argmax_decider.sv
// Result consumer for the LeNet-5 pipeline: captures NUM_CLASSES signed scores on a rising
// in_valid and finds the winning class serially, one class per cycle. LENET_TOP2_EN adds runner-up/margin.
module lenet_argmax_decider #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           out_valid,
  output logic [3:0]                     class_idx,
  output logic signed [SCORE_W-1:0]      max_score
`ifdef LENET_TOP2_EN
  ,
  output logic [3:0]                     second_idx,
  output logic [SCORE_W:0]               margin
`endif
);

  // Output handshake: a result transfers on a cycle where out_valid and out_ready are both
  // high; until then out_valid stays high and every result output is held stable.

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t                     state_q, state_d;
  logic                       prev_v;
  logic                       capture, last, load_result, seed_hi;
  logic [3:0]                 idx_q, best_q, best_d;
  logic signed [SCORE_W-1:0]  score_buf [NUM_CLASSES];
  logic signed [SCORE_W-1:0]  s0, s1, cur, best_val, best_val_d;
`ifdef LENET_TOP2_EN
  logic [3:0]                 second_q, second_d;
  logic signed [SCORE_W-1:0]  second_val, second_val_d;
  logic [SCORE_W:0]           margin_d;
`endif

  assign s0       = scores[SCORE_W-1:0];
  assign s1       = scores[2*SCORE_W-1:SCORE_W];
  assign seed_hi  = s1 > s0;
  assign cur      = score_buf[idx_q];
  assign best_val = score_buf[best_q];
  assign capture  = (state_q == IDLE) && in_valid && !prev_v;
  assign last     = idx_q == 4'(NUM_CLASSES - 1);
  assign busy     = state_q != IDLE;
`ifdef LENET_TOP2_EN
  assign second_val = score_buf[second_q];
  // Both operands widened by one sign bit so the difference always fits.
  assign margin_d   = {best_val_d[SCORE_W-1], best_val_d} - {second_val_d[SCORE_W-1], second_val_d};
`endif

  always_comb begin
    state_d     = state_q;
    load_result = 1'b0;
    best_d      = best_q;
    best_val_d  = best_val;
`ifdef LENET_TOP2_EN
    second_d     = second_q;
    second_val_d = second_val;
`endif
    unique case (state_q)
      IDLE: begin
        // Seed from classes 0 and 1 straight off the input bus; strict compare keeps class 0 on ties.
        best_d     = seed_hi ? 4'd1 : 4'd0;
        best_val_d = seed_hi ? s1 : s0;
`ifdef LENET_TOP2_EN
        second_d     = seed_hi ? 4'd0 : 4'd1;
        second_val_d = seed_hi ? s0 : s1;
`endif
        if (capture) begin
          if (NUM_CLASSES == 2) begin
            state_d     = HOLD;
            load_result = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (cur > best_val) begin
          best_d     = idx_q;
          best_val_d = cur;
`ifdef LENET_TOP2_EN
          second_d     = best_q;
          second_val_d = best_val;
`endif
        end
`ifdef LENET_TOP2_EN
        else if (cur > second_val) begin
          second_d     = idx_q;
          second_val_d = cur;
        end
`endif
        if (last) begin
          state_d     = HOLD;
          load_result = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_v    <= 1'b0;
      idx_q     <= 4'd0;
      best_q    <= 4'd0;
      out_valid <= 1'b0;
      class_idx <= 4'd0;
      max_score <= '0;
`ifdef LENET_TOP2_EN
      second_q   <= 4'd0;
      second_idx <= 4'd0;
      margin     <= '0;
`endif
    end else begin
      state_q <= state_d;
      prev_v  <= in_valid;
      best_q  <= best_d;
`ifdef LENET_TOP2_EN
      second_q <= second_d;
`endif
      if (capture) idx_q <= 4'd2;
      else if (state_q == SCAN && !last) idx_q <= idx_q + 4'd1;
      // The final compare result is registered directly so out_valid rises with it.
      if (load_result) begin
        out_valid <= 1'b1;
        class_idx <= best_d;
        max_score <= best_val_d;
`ifdef LENET_TOP2_EN
        second_idx <= second_d;
        margin     <= margin_d;
`endif
      end else if (state_q == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NUM_CLASSES; k++) score_buf[k] <= scores[k*SCORE_W +: SCORE_W];
    end
  end

endmodule

// File: tb/tb_lenet_argmax_decider.sv
// Bench for lenet_argmax_decider: directed and random score vectors against a top-2 reference model.
module tb_lenet_argmax_decider;
  localparam int N  = 10;
  localparam int W  = 32;
  localparam int RW = 4 + W + 4 + W + 1;

  logic                clk = 1'b0;
  logic                rst, in_valid, out_ready;
  logic [N*W-1:0]      scores;
  logic                busy, out_valid;
  logic [3:0]          class_idx;
  logic signed [W-1:0] max_score;
`ifdef LENET_TOP2_EN
  logic [3:0]          second_idx;
  logic [W:0]          margin;
`endif

  int checks = 0;
  int fails  = 0;
  logic signed [W-1:0] sc [N];
  logic [RW-1:0]       exp_q [$];

  lenet_argmax_decider #(.NUM_CLASSES(N), .SCORE_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .scores(scores), .out_ready(out_ready),
    .busy(busy), .out_valid(out_valid), .class_idx(class_idx), .max_score(max_score)
`ifdef LENET_TOP2_EN
    , .second_idx(second_idx), .margin(margin)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: best = lowest index of the maximum, runner-up = same rule over the rest
  task automatic model_push();
    int b, s;
    longint d;
    logic [W:0] m;
    b = 0;
    for (int k = 1; k < N; k++) if (sc[k] > sc[b]) b = k;
    s = (b == 0) ? 1 : 0;
    for (int k = 0; k < N; k++) if (k != b && sc[k] > sc[s]) s = k;
    d = longint'(sc[b]) - longint'(sc[s]);
    m = d[W:0];
    exp_q.push_back({4'(b), sc[b], 4'(s), m});
  endtask

  // drivers
  task automatic set_scores();
    for (int k = 0; k < N; k++) scores[k*W +: W] = sc[k];
  endtask

  task automatic random_scores(input bool_small);
    for (int k = 0; k < N; k++)
      sc[k] = bool_small ? W'($signed($urandom_range(0, 6)) - 3) : W'($urandom());
  endtask

  // Waits (bounded) for out_valid after in_valid was raised, then performs the handshake.
  task automatic run_inference(output int lat, output logic [RW-1:0] got, output logic busy1,
                               output logic v_after, output logic b_after);
    lat = 0;
    busy1 = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        busy1 = busy;
        for (int k = 0; k < N; k++) scores[k*W +: W] = $urandom();
      end
    end while (!out_valid && lat < 40);
`ifdef LENET_TOP2_EN
    got = {class_idx, max_score, second_idx, margin};
`else
    got = {class_idx, max_score, 4'd0, {(W+1){1'b0}}};
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    v_after = out_valid;
    b_after = busy;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; scores = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (class_idx !== 4'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", class_idx); end
    checks++; if (max_score !== '0) begin fails++; $display("FAIL reset_score: got %0d want 0", max_score); end
`ifdef LENET_TOP2_EN
    checks++; if (second_idx !== 4'd0 || margin !== '0) begin
      fails++; $display("FAIL reset_top2: got %0d/%0d want 0/0", second_idx, margin); end
`endif
  endtask

  task automatic test_directed();
    int lat; logic [RW-1:0] got, exp; logic b1, va, ba;
    for (int v = 0; v < 2; v++) begin
      idle_cycle();
      if (v == 0) begin
        sc[0] = 5; sc[1] = -3; sc[2] = 100; sc[3] = 7; sc[4] = 100;
        sc[5] = 0; sc[6] = -1; sc[7] = 2;   sc[8] = 3; sc[9] = 4;
      end else begin
        sc[0] = 32'sh8000_0000;
        for (int k = 1; k < 8; k++) sc[k] = k;
        sc[8] = 32'sh7fff_ffff; sc[9] = -1;
      end
      set_scores(); model_push(); in_valid = 1'b1;
      run_inference(lat, got, b1, va, ba);
      exp = exp_q.pop_front();
      checks++; if (lat !== N - 1) begin fails++; $display("FAIL dir%0d_latency: got %0d want %0d", v, lat, N - 1); end
      checks++; if (b1 !== 1'b1) begin fails++; $display("FAIL dir%0d_busy: got %b want 1", v, b1); end
      checks++; if (got[RW-1 -: 4+W] !== exp[RW-1 -: 4+W]) begin
        fails++; $display("FAIL dir%0d_result: got %h want %h", v, got[RW-1 -: 4+W], exp[RW-1 -: 4+W]); end
      checks++; if (got[RW-1 -: 4] !== ((v == 0) ? 4'd2 : 4'd8)) begin
        fails++; $display("FAIL dir%0d_idx_const: got %0d", v, got[RW-1 -: 4]); end
`ifdef LENET_TOP2_EN
      checks++; if (got[W+4:0] !== exp[W+4:0]) begin
        fails++; $display("FAIL dir%0d_top2: got %h want %h", v, got[W+4:0], exp[W+4:0]); end
      checks++; if (got[W:0] !== ((v == 0) ? 33'd0 : 33'h0_7fff_fff8)) begin
        fails++; $display("FAIL dir%0d_margin_const: got %h", v, got[W:0]); end
`endif
      checks++; if (va !== 1'b0 || ba !== 1'b0) begin
        fails++; $display("FAIL dir%0d_release: got valid=%b busy=%b want 0/0", v, va, ba); end
    end
  endtask

  task automatic test_random();
    int lat; logic [RW-1:0] got, exp; logic b1, va, ba;
    for (int t = 0; t < 16; t++) begin
      idle_cycle();
      random_scores(t % 2);
      set_scores(); model_push(); in_valid = 1'b1;
      run_inference(lat, got, b1, va, ba);
      exp = exp_q.pop_front();
      checks++; if (lat !== N - 1 || b1 !== 1'b1) begin
        fails++; $display("FAIL rand%0d_timing: got lat=%0d busy=%b want %0d/1", t, lat, b1, N - 1); end
      checks++; if (got[RW-1 -: 4+W] !== exp[RW-1 -: 4+W]) begin
        fails++; $display("FAIL rand%0d_result: got %h want %h", t, got[RW-1 -: 4+W], exp[RW-1 -: 4+W]); end
`ifdef LENET_TOP2_EN
      checks++; if (got[W+4:0] !== exp[W+4:0]) begin
        fails++; $display("FAIL rand%0d_top2: got %h want %h", t, got[W+4:0], exp[W+4:0]); end
`endif
      checks++; if (va !== 1'b0 || ba !== 1'b0) begin
        fails++; $display("FAIL rand%0d_release: got valid=%b busy=%b", t, va, ba); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [RW-1:0] exp; logic [3+W:0] held;
    idle_cycle();
    random_scores(1'b0);
    set_scores(); model_push(); in_valid = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 40);
    exp = exp_q.pop_front();
    held = {class_idx, max_score};
    checks++; if (lat !== N - 1 || held !== exp[RW-1 -: 4+W]) begin
      fails++; $display("FAIL bp_result: got lat=%0d %h want %0d %h", lat, held, N - 1, exp[RW-1 -: 4+W]); end
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c % 4 == 1);
      if (c % 4 == 1) begin random_scores(1'b0); set_scores(); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || {class_idx, max_score} !== held) begin
        fails++; $display("FAIL bp_hold%0d: got v=%b %h want 1 %h", c, out_valid, {class_idx, max_score}, held); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL bp_release: got valid=%b busy=%b want 0/0", out_valid, busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || {class_idx, max_score} !== held) begin
      fails++; $display("FAIL bp_no_queue: got busy=%b v=%b %h", busy, out_valid, {class_idx, max_score}); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [RW-1:0] got, exp; logic b1, va, ba;
    idle_cycle();
    random_scores(1'b0);
    set_scores(); model_push(); in_valid = 1'b1;
    run_inference(lat, got, b1, va, ba);
    exp = exp_q.pop_front();
    checks++; if (lat !== N - 1 || got[RW-1 -: 4+W] !== exp[RW-1 -: 4+W]) begin
      fails++; $display("FAIL b2b_first: got lat=%0d %h want %h", lat, got[RW-1 -: 4+W], exp[RW-1 -: 4+W]); end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL b2b_held_high%0d: got busy=%b v=%b want 0/0", c, busy, out_valid); end
    end
    idle_cycle();
    random_scores(1'b1);
    set_scores(); model_push(); in_valid = 1'b1;
    run_inference(lat, got, b1, va, ba);
    exp = exp_q.pop_front();
    checks++; if (lat !== N - 1 || got[RW-1 -: 4+W] !== exp[RW-1 -: 4+W]) begin
      fails++; $display("FAIL b2b_second: got lat=%0d %h want %h", lat, got[RW-1 -: 4+W], exp[RW-1 -: 4+W]); end
`ifdef LENET_TOP2_EN
    checks++; if (got[W+4:0] !== exp[W+4:0]) begin
      fails++; $display("FAIL b2b_top2: got %h want %h", got[W+4:0], exp[W+4:0]); end
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int lat; logic [RW-1:0] got, exp; logic b1, va, ba;
    idle_cycle();
    random_scores(1'b0);
    set_scores(); in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_scan_state: got busy=%b v=%b want 1/0", busy, out_valid); end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || class_idx !== 4'd0 || max_score !== '0) begin
      fails++; $display("FAIL mid_scan_reset: got busy=%b v=%b idx=%0d score=%0d", busy, out_valid, class_idx, max_score); end
    // in_valid already high when reset releases counts as a fresh edge
    random_scores(1'b0);
    set_scores(); model_push(); in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_inference(lat, got, b1, va, ba);
    exp = exp_q.pop_front();
    checks++; if (lat !== N - 1 || got[RW-1 -: 4+W] !== exp[RW-1 -: 4+W]) begin
      fails++; $display("FAIL post_reset_result: got lat=%0d %h want %0d %h", lat, got[RW-1 -: 4+W], N - 1, exp[RW-1 -: 4+W]); end
`ifdef LENET_TOP2_EN
    checks++; if (got[W+4:0] !== exp[W+4:0]) begin
      fails++; $display("FAIL post_reset_top2: got %h want %h", got[W+4:0], exp[W+4:0]); end
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
